trace_checker: RTL and testbench

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_pkg.sv | 57 +++++
 rtl/trace_fifo.sv | 51 +++++
 rtl/trace_checker.sv | 160 ++++++++++++++++
 tb/tb_trace_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record and error encodings for the trace checker, plus the
// per-record compare helper used by the checker.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ORDER     = 3'd1,
        ERR_VALUE     = 3'd2,
        ERR_UNDERFLOW = 3'd3,
        ERR_LEFTOVER  = 3'd4
    } err_e;

    typedef struct packed {
        kind_e       kind;
        logic [2:0]  rnum;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    localparam int PEEK = 4;

    // Observed records carry only the fields relevant to their kind.
    function automatic err_e rec_compare(input rec_t exp_rec, input rec_t obs_rec);
        err_e code;
        code = ERR_NONE;
        if (exp_rec.kind != obs_rec.kind) begin
            code = ERR_ORDER;
        end else begin
            case (exp_rec.kind)
                KIND_REG: begin
                    if (exp_rec.rnum != obs_rec.rnum || exp_rec.data != obs_rec.data)
                        code = ERR_VALUE;
                end
                KIND_LOAD, KIND_STORE: begin
                    if (exp_rec.addr != obs_rec.addr || exp_rec.data != obs_rec.data)
                        code = ERR_VALUE;
                end
                default: code = ERR_NONE;
            endcase
        end
        return code;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Expected-record FIFO: one push per cycle, up to four pops per cycle,
// with the four head entries visible combinationally.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     srst_i,
    input  logic                     push_i,
    input  rec_t                     push_rec_i,
    input  logic [2:0]               pop_n_i,
    output rec_t                     peek_o [PEEK],
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);

    rec_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     occ_q;

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_ptr_q] <= push_rec_i;
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_ptr_q + AW'(pop_n_i);
            occ_q    <= occ_q + (AW+1)'(push_i) - (AW+1)'(pop_n_i);
        end
    end

    generate
        for (genvar gi = 0; gi < PEEK; gi++) begin : g_peek
            assign peek_o[gi] = mem_q[rd_ptr_q + AW'(gi)];
        end
    endgenerate

    assign occ_o = occ_q;

endmodule

// File: rtl/trace_checker.sv
// Compares per-cycle commit events against a queue of expected records,
// tracking match/error counts and the first error seen until HALT.
module trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [1:0]  exp_kind,
    input  logic [2:0]  exp_reg,
    input  logic [15:0] exp_addr,
    input  logic [15:0] exp_data,
    input  logic        RegWrite,
    input  logic [2:0]  WriteRegister,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    input  logic        Halt,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [15:0] err_cycle,
    output logic [15:0] err_count,
    output logic [15:0] match_count
);

    localparam int OW = $clog2(DEPTH) + 1;

    typedef enum logic {S_RUN, S_DONE} state_e;

    state_e        state_q;
    logic [15:0]   cycle_q;
    logic [15:0]   err_count_q;
    logic [15:0]   match_count_q;
    err_e          err_code_q;
    logic [15:0]   err_cycle_q;
    logic          done_q;
    logic          pass_q;

    rec_t          push_rec;
    rec_t          peek [PEEK];
    logic [OW-1:0] occ;
    logic          active;
    logic          push;
    logic [2:0]    pop_n;

    rec_t          cand [PEEK];
    logic [3:0]    cand_v;
    logic [2:0]    obs_n;
    logic          underflow;
    logic [1:0]    slot;
    err_e          rec_code;
    err_e          first_code;
    logic [2:0]    bad_n;
    logic [2:0]    good_n;
    logic [15:0]   err_count_d;
    logic [15:0]   match_count_d;

    assign active    = (state_q == S_RUN) && !rst;
    assign exp_ready = active && (occ < OW'(DEPTH));
    assign push      = exp_valid && exp_ready;
    assign push_rec  = '{kind: kind_e'(exp_kind), rnum: exp_reg, addr: exp_addr, data: exp_data};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .srst_i     (rst),
        .push_i     (push),
        .push_rec_i (push_rec),
        .pop_n_i    (active ? pop_n : 3'd0),
        .peek_o     (peek),
        .occ_o      (occ)
    );

    // Candidate observed records in their fixed REG, LOAD, STORE, HALT order.
    assign cand_v  = {Halt, MemWrite, MemRead, RegWrite};
    assign cand[0] = '{kind: KIND_REG,   rnum: WriteRegister, addr: 16'h0,      data: WriteData};
    assign cand[1] = '{kind: KIND_LOAD,  rnum: 3'd0,          addr: MemAddress, data: MemDataOut};
    assign cand[2] = '{kind: KIND_STORE, rnum: 3'd0,          addr: MemAddress, data: MemDataIn};
    assign cand[3] = '{kind: KIND_HALT,  rnum: 3'd0,          addr: 16'h0,      data: 16'h0};

    always_comb begin
        obs_n      = 3'd0;
        slot       = 2'd0;
        rec_code   = ERR_NONE;
        first_code = ERR_NONE;
        bad_n      = 3'd0;
        good_n     = 3'd0;
        for (int k = 0; k < PEEK; k++)
            if (cand_v[k]) obs_n = obs_n + 3'd1;
        underflow = OW'(obs_n) > occ;
        pop_n     = underflow ? 3'd0 : obs_n;

        if (underflow) begin
            bad_n      = 3'd1;
            first_code = ERR_UNDERFLOW;
        end else begin
            for (int k = 0; k < PEEK; k++) begin
                if (cand_v[k]) begin
                    rec_code = rec_compare(peek[slot], cand[k]);
                    if (rec_code != ERR_NONE) begin
                        bad_n = bad_n + 3'd1;
                        if (first_code == ERR_NONE) first_code = rec_code;
                    end else begin
                        good_n = good_n + 3'd1;
                    end
                    slot = slot + 2'd1;
                end
            end
        end

        // Leftover is judged on what remains after this cycle's pops, ignoring any push.
        if (Halt && (occ != OW'(pop_n))) begin
            bad_n = bad_n + 3'd1;
            if (first_code == ERR_NONE) first_code = ERR_LEFTOVER;
        end

        err_count_d   = sat_add16(err_count_q, bad_n);
        match_count_d = sat_add16(match_count_q, good_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            cycle_q       <= 16'h0;
            err_count_q   <= 16'h0;
            match_count_q <= 16'h0;
            err_code_q    <= ERR_NONE;
            err_cycle_q   <= 16'h0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else if (state_q == S_RUN) begin
            cycle_q       <= cycle_q + 16'h1;
            err_count_q   <= err_count_d;
            match_count_q <= match_count_d;
            if (err_code_q == ERR_NONE && first_code != ERR_NONE) begin
                err_code_q  <= first_code;
                err_cycle_q <= cycle_q;
            end
            if (Halt) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                pass_q  <= (err_count_d == 16'h0);
            end
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign err_code    = err_code_q;
    assign err_cycle   = err_cycle_q;
    assign err_count   = err_count_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed and randomized checks of trace_checker against a queue-based
// reference model of the expected-record matching rules.
module tb_trace_checker;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_kind;
    logic [2:0]  exp_reg;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic        RegWrite;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;
    logic        Halt;
    logic        done;
    logic        pass;
    logic [2:0]  err_code;
    logic [15:0] err_cycle;
    logic [15:0] err_count;
    logic [15:0] match_count;

    trace_checker #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .exp_valid     (exp_valid),
        .exp_ready     (exp_ready),
        .exp_kind      (exp_kind),
        .exp_reg       (exp_reg),
        .exp_addr      (exp_addr),
        .exp_data      (exp_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemAddress    (MemAddress),
        .MemDataIn     (MemDataIn),
        .MemDataOut    (MemDataOut),
        .Halt          (Halt),
        .done          (done),
        .pass          (pass),
        .err_code      (err_code),
        .err_cycle     (err_cycle),
        .err_count     (err_count),
        .match_count   (match_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of expected records and plain integer counters.
    typedef struct {
        int kind;
        int r;
        int a;
        int d;
    } rec_s;

    rec_s q[$];
    int   m_err, m_match, m_code, m_ecyc, m_cyc;
    bit   m_done, m_pass;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic note_err(input int code);
        m_err = (m_err < 65535) ? m_err + 1 : 65535;
        if (m_code == 0) begin
            m_code = code;
            m_ecyc = m_cyc;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_err = 0; m_match = 0; m_code = 0; m_ecyc = 0; m_cyc = 0;
        m_done = 1'b0; m_pass = 1'b0;
    endtask

    task automatic model_step();
        rec_s obs[$];
        rec_s e;
        bit   rdy;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_done) return;
        rdy = q.size() < DEPTH;
        if (RegWrite) obs.push_back('{0, int'(WriteRegister), 0, int'(WriteData)});
        if (MemRead)  obs.push_back('{1, 0, int'(MemAddress), int'(MemDataOut)});
        if (MemWrite) obs.push_back('{2, 0, int'(MemAddress), int'(MemDataIn)});
        if (Halt)     obs.push_back('{3, 0, 0, 0});
        if (obs.size() > q.size()) begin
            note_err(3);
        end else begin
            foreach (obs[i]) begin
                e = q.pop_front();
                if (e.kind != obs[i].kind) note_err(1);
                else if (e.kind == 0 && (e.r != obs[i].r || e.d != obs[i].d)) note_err(2);
                else if ((e.kind == 1 || e.kind == 2) && (e.a != obs[i].a || e.d != obs[i].d)) note_err(2);
                else m_match = (m_match < 65535) ? m_match + 1 : 65535;
            end
        end
        if (Halt) begin
            if (q.size() > 0) note_err(4);
            m_done = 1'b1;
            m_pass = (m_err == 0);
        end
        if (exp_valid && rdy)
            q.push_back('{int'(exp_kind), int'(exp_reg), int'(exp_addr), int'(exp_data)});
        m_cyc = (m_cyc + 1) & 16'hFFFF;
    endtask

    task automatic clear_inputs();
        exp_valid = 0; exp_kind = 0; exp_reg = 0; exp_addr = 0; exp_data = 0;
        RegWrite = 0; WriteRegister = 0; WriteData = 0; MemRead = 0; MemWrite = 0;
        MemAddress = 0; MemDataIn = 0; MemDataOut = 0; Halt = 0;
    endtask

    // One clock: check ready mid-cycle, advance the model, check registered outputs.
    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !rst && !m_done && (q.size() < DEPTH);
        check("exp_ready", 32'(exp_ready), 32'(exp_rdy));
        if (rst || exp_valid || RegWrite || MemRead || MemWrite || Halt)
            $display("t=%0t cyc=%0d rst=%0b push=%0b k=%0d rw=%0b mr=%0b mw=%0b h=%0b occ=%0d",
                     $time, m_cyc, rst, exp_valid && exp_ready, exp_kind,
                     RegWrite, MemRead, MemWrite, Halt, q.size());
        model_step();
        @(posedge clk);
        #1;
        check("done",        32'(done),        32'(m_done));
        check("pass",        32'(pass),        32'(m_pass));
        check("err_code",    32'(err_code),    32'(m_code));
        check("err_cycle",   32'(err_cycle),   32'(m_ecyc));
        check("err_count",   32'(err_count),   32'(m_err));
        check("match_count", 32'(match_count), 32'(m_match));
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push(input int k, input int r, input int a, input int d);
        clear_inputs();
        exp_valid = 1; exp_kind = 2'(k); exp_reg = 3'(r); exp_addr = 16'(a); exp_data = 16'(d);
        tick();
        clear_inputs();
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    // Drive the commit event matching an expected record, optionally corrupted.
    task automatic apply_rec(input rec_s e, input bit corrupt);
        logic [15:0] d;
        d = 16'(e.d) ^ (corrupt ? 16'h1 : 16'h0);
        case (e.kind)
            0: begin RegWrite = 1; WriteRegister = 3'(e.r); WriteData = d; end
            1: begin MemRead = 1; MemAddress = 16'(e.a); MemDataOut = d; end
            2: begin MemWrite = 1; MemAddress = 16'(e.a); MemDataIn = d; end
            default: Halt = 1;
        endcase
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();

        // Reset state
        do_reset();
        check("reset_done", 32'(done), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);

        // Single REG match
        push(0, 3, 0, 16'h1234);
        RegWrite = 1; WriteRegister = 3; WriteData = 16'h1234;
        tick(); clear_inputs();
        check("req050_match", 32'(match_count), 32'd1);
        check("req050_err", 32'(err_count), 32'd0);

        // REG + LOAD popped together
        do_reset();
        push(0, 1, 0, 16'h0005);
        push(1, 0, 16'h0040, 16'hBEEF);
        RegWrite = 1; WriteRegister = 1; WriteData = 16'h0005;
        MemRead = 1; MemAddress = 16'h0040; MemDataOut = 16'hBEEF;
        tick(); clear_inputs();
        check("req051_match", 32'(match_count), 32'd2);

        // STORE value mismatch at cycle 7
        do_reset();
        push(2, 0, 16'h0010, 16'h00AA);
        idle(6);
        MemWrite = 1; MemAddress = 16'h0010; MemDataIn = 16'h00AB;
        tick(); clear_inputs();
        check("req052_code", 32'(err_code), 32'd2);
        check("req052_cycle", 32'(err_cycle), 32'd7);
        check("req052_count", 32'(err_count), 32'd1);

        // Underflow, then HALT
        do_reset();
        RegWrite = 1; WriteRegister = 2; WriteData = 16'h0001;
        tick(); clear_inputs();
        check("req053_code", 32'(err_code), 32'd3);
        push(3, 0, 0, 0);
        Halt = 1;
        tick(); clear_inputs();
        check("req053_done", 32'(done), 32'd1);
        check("req053_pass", 32'(pass), 32'd0);

        // FIFO full: ninth push refused, all eight still drain as matches
        do_reset();
        for (int i = 0; i < 8; i++) push(0, i, 0, 16'h100 + i);
        check("req054_ready", 32'(exp_ready), 32'd0);
        push(0, 7, 0, 16'hDEAD);
        for (int i = 0; i < 8; i++) begin
            RegWrite = 1; WriteRegister = 3'(i); WriteData = 16'(16'h100 + i);
            tick(); clear_inputs();
        end
        check("req054_match", 32'(match_count), 32'd8);
        check("req054_err", 32'(err_count), 32'd0);

        // Leftover on HALT, frozen counters in DONE, then reset clears all
        do_reset();
        push(3, 0, 0, 0);
        push(0, 2, 0, 0);
        Halt = 1;
        tick(); clear_inputs();
        check("req055_done", 32'(done), 32'd1);
        check("req055_code", 32'(err_code), 32'd4);
        check("req055_pass", 32'(pass), 32'd0);
        RegWrite = 1; MemRead = 1; Halt = 1;
        tick(); tick(); clear_inputs();
        check("req055_frozen_err", 32'(err_count), 32'd1);
        check("req055_frozen_match", 32'(match_count), 32'd1);
        do_reset();
        check("req055_rst_done", 32'(done), 32'd0);
        check("req055_rst_count", 32'(err_count), 32'd0);
        check("req055_rst_match", 32'(match_count), 32'd0);

        // Randomized episodes against the model
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 80 && !m_done; c++) begin
                clear_inputs();
                if ($urandom_range(0, 1) == 1) begin
                    exp_valid = 1;
                    exp_kind  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    exp_reg   = 3'($urandom_range(0, 7));
                    exp_addr  = 16'($urandom_range(0, 3) * 16);
                    exp_data  = 16'($urandom_range(0, 3));
                end
                if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    int last = -1;
                    for (int i = 0; i < q.size() && i < 4; i++) begin
                        if (q[i].kind <= last) break;
                        apply_rec(q[i], $urandom_range(0, 7) == 0);
                        last = q[i].kind;
                        if ($urandom_range(0, 2) == 0) break;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    rec_s r;
                    r = '{int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3) * 16), int'($urandom_range(0, 3))};
                    apply_rec(r, 1'b0);
                end
                if (c == 79) Halt = 1;
                tick();
            end
            clear_inputs();
            for (int c = 0; c < 3; c++) begin
                RegWrite = 1'($urandom_range(0, 1));
                MemWrite = 1'($urandom_range(0, 1));
                exp_valid = 1;
                tick();
            end
        end

        clear_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
